// File: rtl/correlator_scheduler.sv
// ---------------------------------------------------------------------------
// correlator_scheduler
//
// Purpose:
//   Computes the three pairwise correlations (a,b), (a,c) and (b,c) of a
//   10-bit operand triple with one shared combinational correlator. A job is
//   accepted through a start/ready handshake. The pairs are evaluated on three
//   consecutive cycles, and the registered results are presented through a
//   valid/ready handshake. Jobs can run back to back at one every 4 cycles.
//
// Ports:
//   clk            in   1   rising-edge clock
//   rst_n          in   1   synchronous active-low reset
//   start          in   1   request to begin a job with the current a/b/c
//   start_ready    out  1   start is accepted this cycle (comb, no a/b/c path)
//   a, b, c        in   10  operands, sampled only on an accepted start
//   busy           out  1   job in progress (pair evaluation states)
//   out_valid      out  1   results valid, held until out_ready
//   out_ready      in   1   downstream accepts the results
//   ab_correlation out  10  corr(A,B), registered
//   ac_correlation out  10  corr(A,C), registered
//   bc_correlation out  10  corr(B,C), registered
// ---------------------------------------------------------------------------

// Shared combinational correlator: corr = P(x) ^ Q(y), both fixed bit
// permutations of a 10-bit word.
module correlator (
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [9:0] corr
);

  logic [9:0] p_x;
  logic [9:0] q_y;

  assign p_x  = {x[9], x[7], x[5], x[3], x[1], x[0], x[2], x[4], x[6], x[8]};
  assign q_y  = {y[4], y[3], y[9], y[8], y[7], y[6], y[5], y[2], y[1], y[0]};
  assign corr = p_x ^ q_y;

endmodule

module correlator_scheduler (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       start_ready,
  input  logic [9:0] a,
  input  logic [9:0] b,
  input  logic [9:0] c,
  output logic       busy,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [9:0] ab_correlation,
  output logic [9:0] ac_correlation,
  output logic [9:0] bc_correlation
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AB   = 3'd1,
    AC   = 3'd2,
    BC   = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t     state;
  state_t     next_state;

  logic [9:0] op_a;
  logic [9:0] op_b;
  logic [9:0] op_c;

  logic [9:0] corr_x;
  logic [9:0] corr_y;
  logic [9:0] corr_out;

  logic       capture;

  // Ready depends only on state and out_ready, so there is no combinational
  // path from the operand inputs to start_ready.
  assign start_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign capture     = start && start_ready;

  correlator u_correlator (
    .x    (corr_x),
    .y    (corr_y),
    .corr (corr_out)
  );

  // Next-state logic and correlator operand select.
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    corr_x     = op_a;
    corr_y     = op_b;
    unique case (state)
      IDLE: begin
        if (start) next_state = AB;
      end
      AB: begin
        next_state = AC;
      end
      AC: begin
        corr_y     = op_c;
        next_state = BC;
      end
      BC: begin
        corr_x     = op_b;
        corr_y     = op_c;
        next_state = DONE;
      end
      DONE: begin
        // Handshake completes here; a simultaneous start chains the next job.
        if (out_ready) next_state = start ? AB : IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State, operand capture and result registers.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values and ordering between blocks is irrelevant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      busy           <= 1'b0;
      out_valid      <= 1'b0;
      op_a           <= '0;
      op_b           <= '0;
      op_c           <= '0;
      ab_correlation <= '0;
      ac_correlation <= '0;
      bc_correlation <= '0;
    end else begin
      state     <= next_state;
      // Status flags are registered decodes of the next state so they change
      // exactly with the state register.
      busy      <= (next_state == AB) || (next_state == AC) || (next_state == BC);
      out_valid <= (next_state == DONE);

      if (capture) begin
        op_a <= a;
        op_b <= b;
        op_c <= c;
      end

      // One result register written per evaluation state; frozen otherwise.
      case (state)
        AB:      ab_correlation <= corr_out;
        AC:      ac_correlation <= corr_out;
        BC:      bc_correlation <= corr_out;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_correlator_scheduler.sv
// ---------------------------------------------------------------------------
// tb_correlator_scheduler
//
// Self-checking bench for correlator_scheduler. Expected results come from a
// reference correlation computed from per-bit source index tables; timing
// expectations (3-cycle latency, 4-cycle back-to-back period, stall holding,
// reset behaviour) are counted directly in clock cycles.
// ---------------------------------------------------------------------------
module tb_correlator_scheduler;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       start_ready;
  logic [9:0] a;
  logic [9:0] b;
  logic [9:0] c;
  logic       busy;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] ab_correlation;
  logic [9:0] ac_correlation;
  logic [9:0] bc_correlation;

  int checks = 0;
  int errors = 0;

  correlator_scheduler dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .start_ready    (start_ready),
    .a              (a),
    .b              (b),
    .c              (c),
    .busy           (busy),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .ab_correlation (ab_correlation),
    .ac_correlation (ac_correlation),
    .bc_correlation (bc_correlation)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bit i of P(x) is x[P_SRC[i]]; output bit i of Q(y) is y[Q_SRC[i]].
  localparam int P_SRC [10] = '{8, 6, 4, 2, 0, 1, 3, 5, 7, 9};
  localparam int Q_SRC [10] = '{0, 1, 2, 5, 6, 7, 8, 9, 3, 4};

  function automatic logic [9:0] ref_corr(input logic [9:0] x, input logic [9:0] y);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = x[P_SRC[i]] ^ y[Q_SRC[i]];
    return r;
  endfunction

  // Advance one clock; outputs are then sampled 1 ns after the edge and
  // inputs driven here take effect at the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_results(input string name, input logic [9:0] eab,
                               input logic [9:0] eac, input logic [9:0] ebc);
    checks++;
    if ({ab_correlation, ac_correlation, bc_correlation} !== {eab, eac, ebc}) begin
      errors++;
      $display("FAIL %s results: got ab=%h ac=%h bc=%h, expected ab=%h ac=%h bc=%h",
               name, ab_correlation, ac_correlation, bc_correlation, eab, eac, ebc);
    end
  endtask

  task automatic check_flags(input string name, input logic ev, input logic eb,
                             input logic er);
    checks++;
    if ({out_valid, busy, start_ready} !== {ev, eb, er}) begin
      errors++;
      $display("FAIL %s flags: got valid=%b busy=%b start_ready=%b, expected %b %b %b",
               name, out_valid, busy, start_ready, ev, eb, er);
    end
  endtask

  // Count edges from acceptance until out_valid rises, bounded.
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (out_valid !== 1'b1 && lat < 12);
  endtask

  // Single job from IDLE with out_ready held high; checks latency, results
  // and the return to IDLE.
  task automatic do_job(input string name, input logic [9:0] xa, input logic [9:0] xb,
                        input logic [9:0] xc, input logic [9:0] eab,
                        input logic [9:0] eac, input logic [9:0] ebc);
    int lat;
    check_flags({name, " pre"}, 1'b0, 1'b0, 1'b1);
    a = xa; b = xb; c = xc; start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    a = 10'($urandom); b = 10'($urandom); c = 10'($urandom);
    check_flags({name, " AB"}, 1'b0, 1'b1, 1'b0);
    tick();
    lat = 1;
    while (out_valid !== 1'b1 && lat < 12) begin
      tick();
      lat++;
    end
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, expected 3", name, lat);
    end
    check_results(name, eab, eac, ebc);
    tick();
    check_flags({name, " idle"}, 1'b0, 1'b0, 1'b1);
    check_results({name, " held"}, eab, eac, ebc);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    a = 10'h3FF; b = 10'h3FF; c = 10'h3FF;
    tick();
    tick();
    check_flags("reset", 1'b0, 1'b0, 1'b1);
    check_results("reset", 10'h000, 10'h000, 10'h000);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_flags("idle hold", 1'b0, 1'b0, 1'b1);
      check_results("idle hold", 10'h000, 10'h000, 10'h000);
    end
  endtask

  task automatic test_single();
    do_job("single", 10'h001, 10'h000, 10'h000, 10'h010, 10'h010, 10'h000);
  endtask

  task automatic test_mapping();
    do_job("map b=008", 10'h000, 10'h008, 10'h000, 10'h100, 10'h000, 10'h040);
    do_job("map b=3ff", 10'h000, 10'h3FF, 10'h000, 10'h3FF, 10'h000, 10'h3FF);
  endtask

  task automatic test_backpressure();
    logic [9:0] xa, xb, xc;
    int lat;
    xa = 10'($urandom); xb = 10'($urandom); xc = 10'($urandom);
    a = xa; b = xb; c = xc; start = 1'b1; out_ready = 1'b0;
    tick();
    // Start pulses with different operands during AB and AC must be ignored.
    a = ~xa; b = ~xb; c = ~xc; start = 1'b1;
    tick();
    a = xa ^ 10'h155; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check_flags("bp done", 1'b1, 1'b0, 1'b0);
    // Stalled DONE: start with new operands asserted, out_ready low.
    for (int i = 0; i < 6; i++) begin
      a = 10'($urandom); b = 10'($urandom); c = 10'($urandom); start = 1'b1;
      tick();
      check_flags("bp stall", 1'b1, 1'b0, 1'b0);
      check_results("bp stall", ref_corr(xa, xb), ref_corr(xa, xc), ref_corr(xb, xc));
    end
    start = 1'b0; out_ready = 1'b1;
    tick();
    check_flags("bp release", 1'b0, 1'b0, 1'b1);
    check_results("bp release", ref_corr(xa, xb), ref_corr(xa, xc), ref_corr(xb, xc));
    // Nothing was queued by the ignored starts.
    tick();
    check_flags("bp no queue", 1'b0, 1'b0, 1'b1);
    lat = 0;
  endtask

  task automatic test_back_to_back();
    logic [9:0] xa, xb, xc;
    int lat;
    int total;
    out_ready = 1'b1;
    for (int i = 0; i <= 1022; i++) begin
      xa = 10'(i);
      xb = ~xa;
      xc = 10'((xa << 4) + (xa >> 4));
      // First job starts from IDLE, later ones from DONE with the handshake.
      checks++;
      if (start_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b start_ready i=%0d: got %b, expected 1", i, start_ready);
      end
      a = xa; b = xb; c = xc; start = 1'b1;
      tick();
      start = 1'b0;
      a = 10'($urandom); b = 10'($urandom); c = 10'($urandom);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b valid drop i=%0d: got %b, expected 0", i, out_valid);
      end
      wait_valid(lat);
      // Acceptance-to-valid is 3 edges, plus the handshake edge gives period 4.
      total = lat + 1;
      checks++;
      if (total !== 4) begin
        errors++;
        $display("FAIL b2b period i=%0d: got %0d cycles, expected 4", i, total);
      end
      check_results("b2b", ref_corr(xa, xb), ref_corr(xa, xc), ref_corr(xb, xc));
    end
    tick();
    check_flags("b2b end idle", 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic [9:0] xa, xb, xc;
    int lat;
    int stall;
    for (int n = 0; n < 200; n++) begin
      xa = 10'($urandom); xb = 10'($urandom); xc = 10'($urandom);
      stall = $urandom_range(0, 3);
      a = xa; b = xb; c = xc; start = 1'b1; out_ready = 1'b0;
      tick();
      start = 1'b0;
      wait_valid(lat);
      checks++;
      if (lat !== 3) begin
        errors++;
        $display("FAIL rand latency n=%0d: got %0d, expected 3", n, lat);
      end
      for (int s = 0; s < stall; s++) begin
        start = 1'($urandom);
        a = 10'($urandom);
        tick();
      end
      start = 1'b0;
      check_flags("rand valid", 1'b1, 1'b0, 1'b0);
      check_results("rand", ref_corr(xa, xb), ref_corr(xa, xc), ref_corr(xb, xc));
      out_ready = 1'b1;
      tick();
      check_flags("rand idle", 1'b0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_reset_mid_job();
    a = 10'h2A5; b = 10'h13C; c = 10'h0F0; start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    // Now in AC with ab already written; reset at the next edge.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_flags("midreset", 1'b0, 1'b0, 1'b1);
    check_results("midreset", 10'h000, 10'h000, 10'h000);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_flags("midreset quiet", 1'b0, 1'b0, 1'b1);
    end
    do_job("after reset", 10'h1C3, 10'h2B4, 10'h0A5,
           ref_corr(10'h1C3, 10'h2B4), ref_corr(10'h1C3, 10'h0A5),
           ref_corr(10'h2B4, 10'h0A5));
  endtask

  initial begin
    test_reset();
    test_single();
    test_mapping();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid_job();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
